// File: rtl/id_stage_if.sv
// Fetch/decode/execute-facing signal bundle of the instruction-decode stage.
// master is the decode stage itself; slave is the surrounding pipeline.
interface id_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int INS_W  = 32
);
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] current_address;
    logic [4:0]        ex_mem_dest;
    logic              ex_mem_reg_write;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              stall;
    logic              stall_pm;
    logic              pc_mux_sel;
    logic [ADDR_W-1:0] jump_loc;

    logic              idex_valid;
    logic [5:0]        idex_op;
    logic [5:0]        idex_funct;
    logic [DATA_W-1:0] idex_rs_val;
    logic [DATA_W-1:0] idex_rt_val;
    logic [15:0]       idex_imm;
    logic [4:0]        idex_dest;
    logic              idex_reg_write;
    logic              idex_mem_read;
    logic              idex_mem_write;
    logic [ADDR_W-1:0] idex_pc;

    modport master (
        input  ins, current_address, ex_mem_dest, ex_mem_reg_write,
               wb_en, wb_addr, wb_data,
        output stall, stall_pm, pc_mux_sel, jump_loc,
               idex_valid, idex_op, idex_funct, idex_rs_val, idex_rt_val,
               idex_imm, idex_dest, idex_reg_write, idex_mem_read,
               idex_mem_write, idex_pc
    );

    modport slave (
        output ins, current_address, ex_mem_dest, ex_mem_reg_write,
               wb_en, wb_addr, wb_data,
        input  stall, stall_pm, pc_mux_sel, jump_loc,
               idex_valid, idex_op, idex_funct, idex_rs_val, idex_rt_val,
               idex_imm, idex_dest, idex_reg_write, idex_mem_read,
               idex_mem_write, idex_pc
    );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x16 register file, hazard detection,
// BEQ/BNE/J resolution in decode and the registered ID/EX bundle.
module id_stage #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int INS_W  = 32,
    parameter int NREG   = 32
) (
    input  logic       clk,
    input  logic       reset,
    id_stage_if.master bus
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    logic [INS_W-1:0]  ifid_ins;
    logic [ADDR_W-1:0] ifid_pc;
    logic              ifid_valid;
    logic [DATA_W-1:0] regs [NREG];

    logic              idex_valid;
    logic [5:0]        idex_op;
    logic [5:0]        idex_funct;
    logic [DATA_W-1:0] idex_rs_val;
    logic [DATA_W-1:0] idex_rt_val;
    logic [15:0]       idex_imm;
    logic [4:0]        idex_dest;
    logic              idex_reg_write;
    logic              idex_mem_read;
    logic              idex_mem_write;
    logic [ADDR_W-1:0] idex_pc;

    logic [5:0]        op;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
    logic              dec_valid, uses_rs, uses_rt, dec_reg_write;
    logic [4:0]        dec_dest;
    logic              lu_hazard, bh_hazard, hazard, taken, redirect;
    logic              bh_idex, bh_mem;
    logic [ADDR_W-1:0] target;

    assign op  = ifid_ins[31:26];
    assign rs  = ifid_ins[25:21];
    assign rt  = ifid_ins[20:16];
    assign rd  = ifid_ins[15:11];
    assign imm = ifid_ins[15:0];

    // Read ports see a same-cycle writeback; r0 is hard-wired to zero.
    always_comb begin
        rs_val = regs[rs];
        if (bus.wb_en && bus.wb_addr == rs) rs_val = bus.wb_data;
        if (rs == 5'd0) rs_val = '0;
        rt_val = regs[rt];
        if (bus.wb_en && bus.wb_addr == rt) rt_val = bus.wb_data;
        if (rt == 5'd0) rt_val = '0;
    end

    // Unknown opcodes are not real instructions and travel on as bubbles.
    assign is_r    = ifid_valid && (op == OP_R);
    assign is_addi = ifid_valid && (op == OP_ADDI);
    assign is_lw   = ifid_valid && (op == OP_LW);
    assign is_sw   = ifid_valid && (op == OP_SW);
    assign is_beq  = ifid_valid && (op == OP_BEQ);
    assign is_bne  = ifid_valid && (op == OP_BNE);
    assign is_j    = ifid_valid && (op == OP_J);

    assign dec_valid     = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j;
    assign uses_rs       = is_r | is_addi | is_lw | is_sw | is_beq | is_bne;
    assign uses_rt       = is_r | is_sw | is_beq | is_bne;
    assign dec_reg_write = is_r | is_addi | is_lw;
    assign dec_dest      = is_r ? rd : rt;

    assign lu_hazard = idex_valid && idex_mem_read && (idex_dest != 5'd0) &&
                       ((uses_rs && idex_dest == rs) || (uses_rt && idex_dest == rt));

    // Branch operands are compared in decode, so any in-flight producer must drain first.
    assign bh_idex = idex_valid && idex_reg_write &&
                     ((rs != 5'd0 && rs == idex_dest) || (rt != 5'd0 && rt == idex_dest));
    assign bh_mem  = bus.ex_mem_reg_write &&
                     ((rs != 5'd0 && rs == bus.ex_mem_dest) || (rt != 5'd0 && rt == bus.ex_mem_dest));
    assign bh_hazard = (is_beq | is_bne) && (bh_idex | bh_mem);
    assign hazard    = lu_hazard | bh_hazard;

    assign taken    = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) || is_j;
    assign target   = is_j ? ADDR_W'(imm) : ifid_pc + ADDR_W'(1) + ADDR_W'(imm);
    assign redirect = taken && !hazard;

    assign bus.stall      = hazard;
    assign bus.stall_pm   = hazard;
    assign bus.pc_mux_sel = redirect;
    assign bus.jump_loc   = redirect ? target : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_ins   <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (!hazard) begin
            if (redirect) begin
                ifid_ins   <= '0;
                ifid_pc    <= '0;
                ifid_valid <= 1'b0;
            end else begin
                ifid_ins   <= bus.ins;
                ifid_pc    <= bus.current_address;
                ifid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || hazard || !dec_valid) begin
            idex_valid     <= 1'b0;
            idex_op        <= '0;
            idex_funct     <= '0;
            idex_rs_val    <= '0;
            idex_rt_val    <= '0;
            idex_imm       <= '0;
            idex_dest      <= '0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
            idex_pc        <= '0;
        end else begin
            idex_valid     <= 1'b1;
            idex_op        <= op;
            idex_funct     <= ifid_ins[5:0];
            idex_rs_val    <= rs_val;
            idex_rt_val    <= rt_val;
            idex_imm       <= imm;
            idex_dest      <= dec_dest;
            idex_reg_write <= dec_reg_write;
            idex_mem_read  <= is_lw;
            idex_mem_write <= is_sw;
            idex_pc        <= ifid_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.idex_valid     = idex_valid;
    assign bus.idex_op        = idex_op;
    assign bus.idex_funct     = idex_funct;
    assign bus.idex_rs_val    = idex_rs_val;
    assign bus.idex_rt_val    = idex_rt_val;
    assign bus.idex_imm       = idex_imm;
    assign bus.idex_dest      = idex_dest;
    assign bus.idex_reg_write = idex_reg_write;
    assign bus.idex_mem_read  = idex_mem_read;
    assign bus.idex_mem_write = idex_mem_write;
    assign bus.idex_pc        = idex_pc;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a small fetch model drives the stage, expected ID/EX bundles
// are queued when a program is issued and compared as valid instructions emerge.
module tb_id_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if bus_if();
    id_stage dut (.clk(clk), .reset(reset), .bus(bus_if));

    localparam logic [31:0] FILL = 32'hFC00_0000;

    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cnt = 0;
    int          redir_cnt = 0;
    logic [83:0] sb_q [$];
    logic [31:0] pm [logic [15:0]];
    logic [15:0] rmodel [32];
    logic [15:0] pc;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    // Expected ID/EX contents for an instruction, from the bench's own register image.
    function automatic logic [83:0] exp_of(input logic [31:0] i, input logic [15:0] a);
        logic [5:0] op;
        logic       rw, mr, mw;
        logic [4:0] dest;
        op   = i[31:26];
        rw   = (op == 6'h00) || (op == 6'h08) || (op == 6'h23);
        mr   = (op == 6'h23);
        mw   = (op == 6'h2B);
        dest = (op == 6'h00) ? i[15:11] : i[20:16];
        return {op, i[5:0], rmodel[i[25:21]], rmodel[i[20:16]], i[15:0], dest, rw, mr, mw, a};
    endfunction

    function automatic logic [83:0] obs_bundle();
        return {bus_if.idex_op, bus_if.idex_funct, bus_if.idex_rs_val, bus_if.idex_rt_val,
                bus_if.idex_imm, bus_if.idex_dest, bus_if.idex_reg_write,
                bus_if.idex_mem_read, bus_if.idex_mem_write, bus_if.idex_pc};
    endfunction

    function automatic logic [31:0] fetch(input logic [15:0] a);
        return pm.exists(a) ? pm[a] : FILL;
    endfunction

    task automatic set_pc(input logic [15:0] a);
        pc = a;
        bus_if.ins = fetch(a);
        bus_if.current_address = a;
        #1;
    endtask

    // One clock: fetch follows stall/redirect, EX->MEM destination is modelled, outputs scored.
    task automatic tick();
        logic [4:0]  md;
        logic        mrw, s_stall, s_pm, s_sel;
        logic [15:0] s_jl;
        logic [83:0] e;
        md      = bus_if.idex_dest;
        mrw     = bus_if.idex_valid & bus_if.idex_reg_write;
        s_stall = bus_if.stall;
        s_pm    = bus_if.stall_pm;
        s_sel   = bus_if.pc_mux_sel;
        s_jl    = bus_if.jump_loc;
        if (s_stall) stall_cnt++;
        if (s_sel) redir_cnt++;
        @(posedge clk);
        #1;
        if (!s_stall) pc = s_sel ? s_jl : pc + 16'd1;
        bus_if.ex_mem_dest      = md;
        bus_if.ex_mem_reg_write = mrw;
        bus_if.ins              = fetch(pc);
        bus_if.current_address  = pc;
        #1;
        if (s_stall) begin
            check_val("stall_pm", 128'(s_pm), 128'(1'b1));
            check_val("sel_in_stall", 128'(s_sel), 128'(1'b0));
            check_val("stall_bubble", 128'({bus_if.idex_valid, obs_bundle()}), 128'(0));
        end
        if (bus_if.idex_valid) begin
            if (sb_q.size() == 0) begin
                check_val("sb_extra", 128'(1'b1), 128'(1'b0));
            end else begin
                e = sb_q.pop_front();
                check_val("idex_bundle", 128'(obs_bundle()), 128'(e));
            end
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
        check_val("drain_left", 128'(sb_q.size()), 128'(0));
        sb_q.delete();
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
        bus_if.wb_en = 1'b1;
        bus_if.wb_addr = a;
        bus_if.wb_data = d;
        tick();
        bus_if.wb_en = 1'b0;
        #1;
        if (a != 5'd0) rmodel[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_if.ins = FILL;
        bus_if.current_address = '0;
        bus_if.ex_mem_dest = '0;
        bus_if.ex_mem_reg_write = 1'b0;
        bus_if.wb_en = 1'b0;
        bus_if.wb_addr = '0;
        bus_if.wb_data = '0;
        pc = '0;
        for (int i = 0; i < 32; i++) rmodel[i] = '0;

        pm[16'h0000] = enc_i(6'h08, 5'd0, 5'd5, 16'h1234);
        pm[16'h0002] = enc_i(6'h08, 5'd0, 5'd11, 16'h00AB);
        pm[16'h000A] = enc_i(6'h04, 5'd1, 5'd2, 16'h0003);
        pm[16'h000B] = enc_i(6'h08, 5'd0, 5'd9, 16'h0BAD);
        pm[16'h000E] = enc_i(6'h08, 5'd0, 5'd6, 16'h0006);
        pm[16'h0020] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);
        pm[16'h0021] = enc_r(5'd2, 5'd4, 5'd3, 6'h20);
        pm[16'h0030] = enc_i(6'h08, 5'd0, 5'd1, 16'h0007);
        pm[16'h0031] = enc_i(6'h04, 5'd1, 5'd0, 16'h0002);
        pm[16'h0032] = enc_i(6'h2B, 5'd4, 5'd2, 16'h0004);
        pm[16'h0040] = enc_i(6'h08, 5'd7, 5'd8, 16'h0010);
        pm[16'h0042] = enc_r(5'd0, 5'd7, 5'd10, 6'h20);
        pm[16'h0050] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);
        pm[16'h0051] = enc_r(5'd2, 5'd4, 5'd3, 6'h20);
        pm[16'h0056] = enc_i(6'h08, 5'd0, 5'd12, 16'h0001);
        pm[16'h0060] = enc_i(6'h05, 5'd4, 5'd2, 16'hFFF5);
        pm[16'h0061] = enc_i(6'h08, 5'd0, 5'd13, 16'h0BAD);
        pm[16'hFFFF] = enc_i(6'h02, 5'd0, 5'd0, 16'h0002);

        // Reset for two cycles, then first instruction reaches ID/EX two edges later.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        set_pc(16'h0000);
        check_val("rst_stall", 128'(bus_if.stall), 128'(0));
        check_val("rst_stall_pm", 128'(bus_if.stall_pm), 128'(0));
        check_val("rst_pc_mux_sel", 128'(bus_if.pc_mux_sel), 128'(0));
        check_val("rst_jump_loc", 128'(bus_if.jump_loc), 128'(0));
        check_val("rst_idex", 128'({bus_if.idex_valid, obs_bundle()}), 128'(0));
        sb_q.push_back(exp_of(pm[16'h0000], 16'h0000));
        tick();
        check_val("valid_edge1", 128'(bus_if.idex_valid), 128'(0));
        tick();
        check_val("valid_edge2", 128'(bus_if.idex_valid), 128'(1));
        check_val("first_popped", 128'(sb_q.size()), 128'(0));

        // Load-use: one bubble, then ADD with its operands.
        set_pc(16'h0100);
        wr_reg(5'd1, 16'h0011);
        wr_reg(5'd2, 16'h0022);
        wr_reg(5'd4, 16'h0040);
        sb_q.push_back(exp_of(pm[16'h0020], 16'h0020));
        sb_q.push_back(exp_of(pm[16'h0021], 16'h0021));
        stall_cnt = 0;
        set_pc(16'h0020);
        drain(20);
        check_val("lu_stall_cycles", 128'(stall_cnt), 128'(1));

        // Taken BEQ at pc 10: redirect to 14 and squash the wrong-path fetch.
        set_pc(16'h0100);
        wr_reg(5'd1, 16'h0005);
        wr_reg(5'd2, 16'h0005);
        sb_q.push_back(exp_of(pm[16'h000A], 16'h000A));
        sb_q.push_back(exp_of(pm[16'h000E], 16'h000E));
        set_pc(16'h000A);
        tick();
        check_val("beq_sel", 128'(bus_if.pc_mux_sel), 128'(1));
        check_val("beq_target", 128'(bus_if.jump_loc), 128'(16'd14));
        tick();
        check_val("beq_sel_drop", 128'(bus_if.pc_mux_sel), 128'(0));
        tick();
        check_val("beq_squash", 128'(bus_if.idex_valid), 128'(0));
        tick();
        check_val("beq_drained", 128'(sb_q.size()), 128'(0));

        // Taken BNE whose unsigned offset wraps: 0x60 + 1 + 0xFFF5 = 0x0056.
        set_pc(16'h0100);
        sb_q.push_back(exp_of(pm[16'h0060], 16'h0060));
        sb_q.push_back(exp_of(pm[16'h0056], 16'h0056));
        set_pc(16'h0060);
        tick();
        check_val("bne_sel", 128'(bus_if.pc_mux_sel), 128'(1));
        check_val("bne_target", 128'(bus_if.jump_loc), 128'(16'h0056));
        drain(10);

        // ADDI r1 then BEQ r1,r0: hazard held through ID/EX and MEM, then falls through.
        set_pc(16'h0100);
        sb_q.push_back(exp_of(pm[16'h0030], 16'h0030));
        sb_q.push_back(exp_of(pm[16'h0031], 16'h0031));
        sb_q.push_back(exp_of(pm[16'h0032], 16'h0032));
        stall_cnt = 0;
        redir_cnt = 0;
        set_pc(16'h0030);
        drain(20);
        check_val("bh_stall_cycles", 128'(stall_cnt), 128'(2));
        check_val("bh_not_taken", 128'(redir_cnt), 128'(0));

        // Writeback bypass into decode, and writes to r0 are ignored.
        set_pc(16'h0100);
        rmodel[7] = 16'hBEEF;
        sb_q.push_back(exp_of(pm[16'h0040], 16'h0040));
        set_pc(16'h0040);
        tick();
        bus_if.wb_en = 1'b1;
        bus_if.wb_addr = 5'd7;
        bus_if.wb_data = 16'hBEEF;
        #1;
        tick();
        check_val("bypass_rs", 128'(bus_if.idex_rs_val), 128'(16'hBEEF));
        bus_if.wb_addr = 5'd0;
        bus_if.wb_data = 16'h1111;
        sb_q.push_back(exp_of(pm[16'h0042], 16'h0042));
        set_pc(16'h0042);
        tick();
        tick();
        check_val("r0_reads_zero", 128'(bus_if.idex_rs_val), 128'(0));
        bus_if.wb_en = 1'b0;
        #1;
        check_val("r0_drained", 128'(sb_q.size()), 128'(0));

        // Reset during a load-use stall clears everything at that edge.
        set_pc(16'h0100);
        sb_q.push_back(exp_of(pm[16'h0050], 16'h0050));
        set_pc(16'h0050);
        tick();
        tick();
        check_val("lu_stall_before_reset", 128'(bus_if.stall), 128'(1));
        reset = 1'b1;
        tick();
        check_val("reset_idex", 128'({bus_if.idex_valid, obs_bundle()}), 128'(0));
        check_val("reset_stall", 128'(bus_if.stall), 128'(0));
        reset = 1'b0;
        for (int i = 0; i < 32; i++) rmodel[i] = '0;
        set_pc(16'h0100);
        repeat (3) tick();

        // J at the top of the address space goes to its immediate.
        sb_q.push_back(exp_of(pm[16'hFFFF], 16'hFFFF));
        sb_q.push_back(exp_of(pm[16'h0002], 16'h0002));
        set_pc(16'hFFFF);
        tick();
        check_val("j_sel", 128'(bus_if.pc_mux_sel), 128'(1));
        check_val("j_target", 128'(bus_if.jump_loc), 128'(16'h0002));
        tick();
        tick();
        check_val("j_squash", 128'(bus_if.idex_valid), 128'(0));
        tick();
        check_val("j_drained", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
